// File: rtl/alu_pkg.sv
// Shared ALU types: sequencer FSM states and the NZCV flag bundle used by the
// ALU top, the status register and the multi-precision sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_multiprec_seq.sv
// Multi-precision add/subtract sequencer: walks an external N-bit adder over
// WORDS slices LSB first, chains the carry and reports whole-word NZCV flags.
module alu_multiprec_seq
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             op_sub,
    input  logic             carry_in,
    output logic [N-1:0]     cpa_a,
    output logic [N-1:0]     cpa_b,
    output logic             cpa_c,
    input  logic [N-1:0]     cpa_s,
    input  logic             cpa_c_out,
    input  logic             cpa_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic              sub_q, sub_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      result_q, result_d;
    alu_flags_t        flags_q, flags_d;
    logic              out_valid_q, out_valid_d;

    logic [N-1:0]      sl_a_s;
    logic [N-1:0]      sl_b_s;
    logic              run_s;
    logic              last_s;
    logic              slice_zero_s;

    assign run_s        = (state_q == RUN);
    assign last_s       = (idx_q == IDX_W'(WORDS - 1));
    assign slice_zero_s = (cpa_s == {N{1'b0}});

    // Slice mux: pick the current N-bit window of the latched operands.
    always_comb begin
        sl_a_s = {N{1'b0}};
        sl_b_s = {N{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            sl_a_s = sl_a_s | ((idx_q == IDX_W'(k)) ? a_q[k*N +: N] : {N{1'b0}});
            sl_b_s = sl_b_s | ((idx_q == IDX_W'(k)) ? b_q[k*N +: N] : {N{1'b0}});
        end
    end

    // Adder drive: operands only while walking slices, B inverted for subtract.
    always_comb begin
        if (run_s) begin
            cpa_a = sl_a_s;
            cpa_b = sl_b_s ^ {N{sub_q}};
            cpa_c = carry_q;
        end else begin
            cpa_a = {N{1'b0}};
            cpa_b = {N{1'b0}};
            cpa_c = 1'b0;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        sub_d       = sub_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = op_sub;
                    carry_d = carry_in;
                    zacc_d  = 1'b1;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < WORDS; k++) begin
                    result_d[k*N +: N] = (idx_q == IDX_W'(k)) ? cpa_s : result_q[k*N +: N];
                end
                carry_d = cpa_c_out;
                zacc_d  = zacc_q & slice_zero_s;
                if (last_s) begin
                    // Z spans every slice, so fold in the accumulated zero test.
                    flags_d.n   = cpa_s[N-1];
                    flags_d.z   = zacc_q & slice_zero_s;
                    flags_d.c   = cpa_c_out;
                    flags_d.v   = cpa_v;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            result_q    <= {W{1'b0}};
            flags_q     <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            sub_q       <= sub_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_n    = flags_q.n;
    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_multiprec_seq.sv
// Bench for alu_multiprec_seq: a 4-slice instance and a 1-slice instance,
// each wired to a behavioural carry-propagate adder, checked via a scoreboard.
module tb_alu_multiprec_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-slice DUT
    logic         in_valid, in_ready, op_sub, carry_in, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [N-1:0] cpa_a, cpa_b, cpa_s;
    logic         cpa_c, cpa_c_out, cpa_v;
    logic         flag_n, flag_z, flag_c, flag_v;

    alu_multiprec_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .carry_in(carry_in),
        .cpa_a(cpa_a), .cpa_b(cpa_b), .cpa_c(cpa_c),
        .cpa_s(cpa_s), .cpa_c_out(cpa_c_out), .cpa_v(cpa_v),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    assign {cpa_c_out, cpa_s} = {1'b0, cpa_a} + {1'b0, cpa_b} + {{N{1'b0}}, cpa_c};
    assign cpa_v = (cpa_a[N-1] == cpa_b[N-1]) && (cpa_s[N-1] != cpa_a[N-1]);

    // 1-slice DUT
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [N-1:0] a1, b1, result1, cpa_a1, cpa_b1, cpa_s1;
    logic         cpa_c1, cpa_c_out1, cpa_v1;
    logic         flag_n1, flag_z1, flag_c1, flag_v1;

    alu_multiprec_seq #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op_sub(1'b0), .carry_in(1'b0),
        .cpa_a(cpa_a1), .cpa_b(cpa_b1), .cpa_c(cpa_c1),
        .cpa_s(cpa_s1), .cpa_c_out(cpa_c_out1), .cpa_v(cpa_v1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .flag_n(flag_n1), .flag_z(flag_z1), .flag_c(flag_c1), .flag_v(flag_v1)
    );

    assign {cpa_c_out1, cpa_s1} = {1'b0, cpa_a1} + {1'b0, cpa_b1} + {{N{1'b0}}, cpa_c1};
    assign cpa_v1 = (cpa_a1[N-1] == cpa_b1[N-1]) && (cpa_s1[N-1] != cpa_a1[N-1]);

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic sub, input logic cin);
        logic [W-1:0] be;
        logic [W:0]   sum;
        exp_t         e;
        be     = sub ? ~mb : mb;
        sum    = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, cin};
        e.res  = sum[W-1:0];
        e.nzcv = {sum[W-1], (sum[W-1:0] == {W{1'b0}}), sum[W],
                  (ma[W-1] == be[W-1]) && (sum[W-1] != ma[W-1])};
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    // One operation on the 4-slice DUT with fixed-latency and handshake checks.
    task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic sub, input logic cin, input int stall);
        exp_t e;
        check({tag, ".ready_idle"}, 64'(in_ready), 64'd1);
        a = ia; b = ib; op_sub = sub; carry_in = cin; in_valid = 1'b1;
        sb_q.push_back(model(ia, ib, sub, cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".ready_run"}, 64'(in_ready), 64'd0);
        check({tag, ".valid_early"}, 64'(out_valid), 64'd0);
        for (int k = 1; k <= WORDS; k++) begin
            @(posedge clk); #1;
            if (k < WORDS) begin
                check({tag, ".valid_early"}, 64'(out_valid), 64'd0);
            end else begin
                check({tag, ".valid_on_time"}, 64'(out_valid), 64'd1);
            end
            check({tag, ".ready_busy"}, 64'(in_ready), 64'd0);
        end
        e = sb_q.pop_front();
        check({tag, ".result"}, 64'(result), 64'(e.res));
        check({tag, ".nzcv"}, 64'(flags_now()), 64'(e.nzcv));
        if (stall > 0) begin
            a = ~ia; b = ib + 32'd3; in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".stall_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".stall_result"}, 64'(result), 64'(e.res));
            check({tag, ".stall_nzcv"}, 64'(flags_now()), 64'(e.nzcv));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_clear"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; carry_in = 1'b0;
        a = '0; b = '0; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.nzcv", 64'(flags_now()), 64'd0);
        check("rst.ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
        do_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        do_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        do_op("sub_equal",  32'h12345678, 32'h12345678, 1'b1, 1'b1, 0);
        do_op("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 1'b1, 0);
        do_op("z_low",      32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);
        do_op("z_top",      32'h01000000, 32'h00000000, 1'b0, 1'b0, 0);
        do_op("adc_mix",    32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1, 0);
        do_op("sbc_mix",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 0);
        do_op("backpress",  32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 3);

        // Abort an operation after two slices with an asynchronous reset.
        a = 32'h11111111; b = 32'h22222222; op_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("abort.valid", 64'(out_valid), 64'd0);
        check("abort.nzcv", 64'(flags_now()), 64'd0);
        check("abort.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WORDS + 1; k++) begin
            @(posedge clk); #1;
            check("abort.no_valid", 64'(out_valid), 64'd0);
        end
        check("abort.ready_after", 64'(in_ready), 64'd1);
        do_op("after_abort", 32'd5, 32'd7, 1'b0, 1'b0, 0);

        // Single-slice build: 0x80 + 0x80.
        a1 = 8'h80; b1 = 8'h80; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("w1.valid_early", 64'(out_valid1), 64'd0);
        check("w1.ready_run", 64'(in_ready1), 64'd0);
        @(posedge clk); #1;
        check("w1.valid", 64'(out_valid1), 64'd1);
        check("w1.result", 64'(result1), 64'h00);
        check("w1.nzcv", 64'({flag_n1, flag_z1, flag_c1, flag_v1}), 64'b0111);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("w1.valid_clear", 64'(out_valid1), 64'd0);
        check("w1.ready_back", 64'(in_ready1), 64'd1);

        check("sb.empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/alu_multiprec_seq.md
Name: alu_multiprec_seq

Overview:
Multi-precision add/subtract sequencer on the ALU's input side. Accepts WORDS*N-bit operands and drives the N-bit carry-propagate adder one slice per cycle, least-significant slice first. It chains the carry between slices and assembles the wide result. It returns whole-word NZCV flags to the consumer over a valid/ready handshake. The adder stays instantiated in the ALU top; this block connects to it through the cpa_* ports.

Parameters:
N, 8, slice width; must match the adder's N.
WORDS, 4, slices per operation; must be >= 1. Operand/result width is W = N*WORDS.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid & in_ready.
a  in  W  operand A.
b  in  W  operand B.
op_sub  in  1  1: compute a + ~b + carry_in; 0: compute a + b + carry_in.
carry_in  in  1  initial carry (SUB = op_sub 1 with carry_in 1).
cpa_a  out  N  slice of A driven to the adder.
cpa_b  out  N  slice of B driven to the adder, inverted when sub.
cpa_c  out  1  carry into the adder.
cpa_s  in  N  adder sum, combinational in the same cycle.
cpa_c_out  in  1  adder carry out.
cpa_v  in  1  adder overflow flag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
result  out  W  wide sum.
flag_n, flag_z, flag_c, flag_v  out  1 each  whole-word flags.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (asynchronous, rst_n low) forces the following:
  - state IDLE, slice index 0, carry register 0;
  - out_valid 0, result 0, all flags 0.
- in_ready = (state == IDLE). It reads 1 while rst_n is low, so sources must not handshake during reset.
- IDLE:
  - On accept, latch a, b, op_sub, and carry_in into the carry register.
  - Clear the zero accumulator to 1 and set idx = 0. Go to RUN.
- RUN, cycle k (idx = k):
  - Drive cpa_a = a[k*N +: N] and cpa_b = b[k*N +: N], XOR {N{op_sub}}. Drive cpa_c = carry register.
  - On the clock edge: result[k*N +: N] <= cpa_s; carry <= cpa_c_out; zacc <= zacc & (cpa_s == 0).
  - If k == WORDS-1, also perform the final-slice update below and go to DONE. Otherwise idx <= k+1.
- Final-slice update (on the last RUN edge):
  - flag_n <= cpa_s[N-1], flag_c <= cpa_c_out, flag_v <= cpa_v.
  - flag_z <= zacc & (cpa_s == 0).
  - out_valid <= 1.
- Flag semantics: Z covers the full W bits, not the last slice. C follows the carry = no-borrow convention on SUB.
- Outside RUN, cpa_a, cpa_b and cpa_c are driven 0.
- DONE:
  - out_valid held at 1; result and flags held stable.
  - On out_valid & out_ready, clear out_valid and go to IDLE.
  - in_valid is ignored, since in_ready is 0.
- Timing:
  - Latency: request accepted at edge T; out_valid rises after edge T+WORDS.
  - Throughput is one op per WORDS+2 cycles minimum. There is no overlap between operations.
- result and flags keep their last values until the final-slice edge of the next operation. out_valid is the only qualifier.
- Reset mid-operation aborts the op: no out_valid is produced and the block is back in IDLE when rst_n releases.
- WORDS = 1 degenerates to a single RUN cycle.

Decomposition:
- Package alu_pkg holds the FSM state typedef (IDLE/RUN/DONE) and a flags struct {n, z, c, v} shared with the ALU top and the status register.
- The slice index width is $clog2(WORDS), minimum 1, as a localparam.
- No sub-module; the adder remains external. The bench instantiates the adder and wires the cpa_* ports.

Test Plan:
1. ADD, a=0x000000FF, b=0x00000001, carry_in=0 -> result 0x00000100, N=0 Z=0 C=0 V=0. out_valid rises exactly 4 edges after accept; in_ready is 0 during RUN/DONE.
2. ADD, a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, N=1 V=1 C=0 Z=0. Then a=0xFFFFFFFF, b=1 -> result 0, C=1 Z=1 V=0.
3. SUB, a=b=0x12345678, op_sub=1, carry_in=1 -> result 0, Z=1 C=1 V=0 N=0. Then a=0, b=1 -> result 0xFFFFFFFF, C=0 N=1.
4. Whole-word Z: a=0x00000001, b=0 -> Z=0 although the top slice sums to 0. Also a=0x01000000, b=0 -> Z=0.
5. Backpressure: out_ready held low 3 cycles after out_valid, with in_valid high -> out_valid, result and flags stable, no new accept. out_ready high -> IDLE next cycle, in_ready=1.
6. Reset abort: assert rst_n low after 2 RUN slices -> out_valid 0, flags 0 and in_ready 1 after release. A following ADD 5+7 completes with result 12.
7. WORDS=1 build: a=0x80, b=0x80 -> result 0x00, C=1 V=1 Z=1 N=0, out_valid after 1 RUN edge.
